fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 10'd0: byte address fetched first after reset; bits [1:0] are treated as 0.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that stops fetch.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 ProgCounter  output  10  byte address driven to instruction memory; always word-aligned, bits [1:0] = 0.
REQ-006 InstrIn  input  32  instruction word returned combinationally by memory for the current ProgCounter.
REQ-007 InstrOut  output  32  registered instruction presented to decode.
REQ-008 PCOut  output  10  byte address of InstrOut.
REQ-009 InstrValid  output  1  InstrOut/PCOut hold a deliverable instruction.
REQ-010 DecodeReady  input  1  decode accepts InstrOut this cycle when InstrValid=1.
REQ-011 BranchTaken  input  1  single-cycle redirect request from execute.
REQ-012 BranchTarget  input  10  redirect byte address; bits [1:0] are ignored and forced to 0.
REQ-013 Halted  output  1  sequencer is in HALTED state.
REQ-014 FetchCount  output  16  count of accepted instructions, saturating at 16'hFFFF.

Function
REQ-015 The block SHALL implement two states, FETCH and HALTED, plus a one-entry output register (InstrOut, PCOut, InstrValid).
REQ-016 A handshake SHALL occur in a cycle with InstrValid=1 and DecodeReady=1; FetchCount SHALL increment on each handshake unless it is at 16'hFFFF.
REQ-017 In FETCH, with BranchTaken=0: when the output register is empty or a handshake occurs, the block SHALL load InstrIn and ProgCounter into InstrOut/PCOut, set InstrValid=1, and advance ProgCounter by 4.
REQ-018 In FETCH, with BranchTaken=0 and InstrValid=1 but no handshake (stall): ProgCounter, InstrOut, PCOut and InstrValid SHALL hold.
REQ-019 Fetch latency SHALL be one cycle: an address on ProgCounter at edge N appears on PCOut with InstrValid=1 after edge N+1.
REQ-020 Back-to-back handshakes SHALL sustain one instruction per cycle.
REQ-021 ProgCounter increment SHALL wrap modulo 1024: 10'd1020 + 4 = 10'd0.
REQ-022 If the word loaded under REQ-017 equals HALT_WORD:
  - the block SHALL enter HALTED with InstrValid=0;
  - it SHALL not present that word and SHALL not advance ProgCounter, which stays at the halt word's address.
REQ-023 In HALTED: Halted=1, InstrValid=0, ProgCounter frozen, DecodeReady ignored.
REQ-024 BranchTaken=1 in any state SHALL take priority over fetch, stall and halt detection:
  - ProgCounter <= {BranchTarget[9:2], 2'b00};
  - InstrValid <= 0 (flush);
  - state <= FETCH; Halted <= 0.
REQ-025 A handshake in the same cycle as BranchTaken SHALL still count in FetchCount; the flushed instruction is otherwise discarded.
REQ-026 After a redirect, the target word SHALL be fetched on the following cycle per REQ-017, since the output register is then empty.

Reset
REQ-027 Reset=1 at a clock edge SHALL set:
  - ProgCounter=RESET_PC with bits [1:0] forced to 0;
  - InstrOut=0, PCOut=0, InstrValid=0, Halted=0, FetchCount=0;
  - state=FETCH.
REQ-028 Reset SHALL override BranchTaken, DecodeReady and halt detection in the same cycle, including mid-stall and in HALTED.
REQ-029 The first fetch after reset SHALL occur on the first edge with Reset=0.

Verification
REQ-030 Stream: mem[0..3]=0x11,0x22,0x33,0x44, DecodeReady=1 held -> InstrOut 0x11,0x22,0x33,0x44 with PCOut 0,4,8,12 on consecutive cycles; FetchCount=4.
REQ-031 Stall: DecodeReady=0 for 3 cycles while InstrOut=0x22 -> InstrOut/PCOut/ProgCounter hold (0x22/4/8); FetchCount unchanged; 0x33 follows one cycle after DecodeReady=1.
REQ-032 Branch: BranchTaken=1, BranchTarget=10'd203 while stalled -> next cycle InstrValid=0 and ProgCounter=200; the cycle after, PCOut=200 with mem[50].
REQ-033 Halt: mem[2]=32'hFFFF_FFFF -> words 0 and 1 delivered, then Halted=1, InstrValid=0, ProgCounter=8 frozen for 10 cycles; BranchTaken to 0 resumes at PCOut=0.
REQ-034 Wrap: BranchTaken to 1020 -> PCOut sequence 1020, 0, 4.
REQ-035 Reset mid-op: Reset=1 together with BranchTaken=1 during a stall -> next cycle ProgCounter=RESET_PC, InstrValid=0, FetchCount=0, Halted=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Bundle of signals between fetch_sequencer, instruction
//                memory, decode and execute. The slave side is the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_sequencer_if;
  logic [9:0]  ProgCounter;
  logic [31:0] InstrIn;
  logic [31:0] InstrOut;
  logic [9:0]  PCOut;
  logic        InstrValid;
  logic        DecodeReady;
  logic        BranchTaken;
  logic [9:0]  BranchTarget;
  logic        Halted;
  logic [15:0] FetchCount;

  // Sequencer side
  modport slave (
    output ProgCounter, InstrOut, PCOut, InstrValid, Halted, FetchCount,
    input  InstrIn, DecodeReady, BranchTaken, BranchTarget
  );

  // Environment side (memory, decode, execute)
  modport master (
    input  ProgCounter, InstrOut, PCOut, InstrValid, Halted, FetchCount,
    output InstrIn, DecodeReady, BranchTaken, BranchTarget
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch sequencer with a one-entry output register,
//                decode backpressure, branch redirect, halt-word detection
//                and a saturating count of accepted instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [9:0]  RESET_PC  = 10'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  wire logic         clk,
  input  wire logic         Reset,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Clears the byte-offset bits so every address is word aligned
  localparam logic [9:0]  c_ALIGN_MASK = 10'h3FC;
  localparam logic [15:0] c_COUNT_MAX  = 16'hFFFF;

  state_t      r_state;
  logic [9:0]  r_pc;
  logic [31:0] r_instr;
  logic [9:0]  r_pcout;
  logic        r_valid;
  logic [15:0] r_count;

  state_t      w_state_nxt;
  logic [9:0]  w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [9:0]  w_pcout_nxt;
  logic        w_valid_nxt;
  logic [15:0] w_count_nxt;
  logic        w_handshake;
  logic [9:0]  w_target;

  // r_valid is always 0 in HALTED, so no handshake can occur there
  assign w_handshake = r_valid & bus.DecodeReady;
  assign w_target    = bus.BranchTarget & c_ALIGN_MASK;

  // Next-state and datapath decisions; redirect outranks fetch, stall and halt
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pcout_nxt = r_pcout;
    w_valid_nxt = r_valid;
    w_count_nxt = r_count;

    // A handshake counts even when the same cycle flushes the register
    if (w_handshake && (r_count != c_COUNT_MAX)) begin
      w_count_nxt = r_count + 16'd1;
    end

    if (bus.BranchTaken) begin
      w_pc_nxt    = w_target;
      w_valid_nxt = 1'b0;
      w_state_nxt = ST_FETCH;
    end else if ((r_state == ST_FETCH) && (!r_valid || w_handshake)) begin
      if (bus.InstrIn == HALT_WORD) begin
        // Halt word is never presented; PC parks on its address
        w_state_nxt = ST_HALTED;
        w_valid_nxt = 1'b0;
      end else begin
        w_instr_nxt = bus.InstrIn;
        w_pcout_nxt = r_pc;
        w_valid_nxt = 1'b1;
        w_pc_nxt    = r_pc + 10'd4;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC & c_ALIGN_MASK;
      r_instr <= 32'd0;
      r_pcout <= 10'd0;
      r_valid <= 1'b0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pcout <= w_pcout_nxt;
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.ProgCounter = r_pc;
  assign bus.InstrOut    = r_instr;
  assign bus.PCOut       = r_pcout;
  assign bus.InstrValid  = r_valid;
  assign bus.Halted      = (r_state == ST_HALTED);
  assign bus.FetchCount  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed vector bench for fetch_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

  typedef struct {
    logic        rst;
    logic        dr;
    logic        bt;
    logic [9:0]  tgt;
    logic        chk_data;   // compare InstrOut/PCOut only when meaningful
    logic        valid;
    logic [31:0] instr;
    logic [9:0]  pcout;
    logic [9:0]  pc;
    logic        halted;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem [256];
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        vecs [22];

  fetch_sequencer_if bus ();

  assign bus.InstrIn = mem[bus.ProgCounter[9:2]];

  fetch_sequencer #(
    .RESET_PC  (10'd0),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic d, input logic b,
                              input logic [9:0] t, input logic cd, input logic v,
                              input logic [31:0] ins, input logic [9:0] po,
                              input logic [9:0] p, input logic h, input logic [15:0] c);
    vec_t x;
    x.rst = r; x.dr = d; x.bt = b; x.tgt = t; x.chk_data = cd; x.valid = v;
    x.instr = ins; x.pcout = po; x.pc = p; x.halted = h; x.cnt = c;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then check all outputs
  task automatic step(input vec_t v, input string nm);
    rst              = v.rst;
    bus.DecodeReady  = v.dr;
    bus.BranchTaken  = v.bt;
    bus.BranchTarget = v.tgt;
    @(posedge clk);
    #1;
    chk({nm, ".valid"},  {31'd0, bus.InstrValid}, {31'd0, v.valid});
    chk({nm, ".pc"},     {22'd0, bus.ProgCounter}, {22'd0, v.pc});
    chk({nm, ".halted"}, {31'd0, bus.Halted},      {31'd0, v.halted});
    chk({nm, ".count"},  {16'd0, bus.FetchCount},  {16'd0, v.cnt});
    if (v.chk_data) begin
      chk({nm, ".instr"}, bus.InstrOut,            v.instr);
      chk({nm, ".pcout"}, {22'd0, bus.PCOut},      {22'd0, v.pcout});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    //             rst dr bt tgt     cd v  instr          po     pc     h  cnt
    // streaming, four accepted
    vecs[0]  = mk(1, 0, 0, 10'd0,   1, 0, 32'h0,         10'd0,    10'd0,    0, 16'd0);
    vecs[1]  = mk(0, 1, 0, 10'd0,   1, 1, 32'h11,        10'd0,    10'd4,    0, 16'd0);
    vecs[2]  = mk(0, 1, 0, 10'd0,   1, 1, 32'h22,        10'd4,    10'd8,    0, 16'd1);
    vecs[3]  = mk(0, 1, 0, 10'd0,   1, 1, 32'h33,        10'd8,    10'd12,   0, 16'd2);
    vecs[4]  = mk(0, 1, 0, 10'd0,   1, 1, 32'h44,        10'd12,   10'd16,   0, 16'd3);
    vecs[5]  = mk(0, 1, 0, 10'd0,   1, 1, 32'h1000_0004, 10'd16,   10'd20,   0, 16'd4);
    // stall on 0x22 for three cycles
    vecs[6]  = mk(1, 1, 0, 10'd0,   1, 0, 32'h0,         10'd0,    10'd0,    0, 16'd0);
    vecs[7]  = mk(0, 0, 0, 10'd0,   1, 1, 32'h11,        10'd0,    10'd4,    0, 16'd0);
    vecs[8]  = mk(0, 1, 0, 10'd0,   1, 1, 32'h22,        10'd4,    10'd8,    0, 16'd1);
    vecs[9]  = mk(0, 0, 0, 10'd0,   1, 1, 32'h22,        10'd4,    10'd8,    0, 16'd1);
    vecs[10] = mk(0, 0, 0, 10'd0,   1, 1, 32'h22,        10'd4,    10'd8,    0, 16'd1);
    vecs[11] = mk(0, 0, 0, 10'd0,   1, 1, 32'h22,        10'd4,    10'd8,    0, 16'd1);
    vecs[12] = mk(0, 1, 0, 10'd0,   1, 1, 32'h33,        10'd8,    10'd12,   0, 16'd2);
    // branch to 203 while stalled
    vecs[13] = mk(0, 0, 0, 10'd0,   1, 1, 32'h33,        10'd8,    10'd12,   0, 16'd2);
    vecs[14] = mk(0, 0, 1, 10'd203, 0, 0, 32'h0,         10'd0,    10'd200,  0, 16'd2);
    vecs[15] = mk(0, 0, 0, 10'd0,   1, 1, 32'h1000_0032, 10'd200,  10'd204,  0, 16'd2);
    // branch with handshake in same cycle still counts; then wrap
    vecs[16] = mk(0, 1, 1, 10'd1022,0, 0, 32'h0,         10'd0,    10'd1020, 0, 16'd3);
    vecs[17] = mk(0, 1, 0, 10'd0,   1, 1, 32'h1000_00FF, 10'd1020, 10'd0,    0, 16'd3);
    vecs[18] = mk(0, 1, 0, 10'd0,   1, 1, 32'h11,        10'd0,    10'd4,    0, 16'd4);
    vecs[19] = mk(0, 1, 0, 10'd0,   1, 1, 32'h22,        10'd4,    10'd8,    0, 16'd5);
    // reset together with branch during a stall
    vecs[20] = mk(0, 0, 0, 10'd0,   1, 1, 32'h22,        10'd4,    10'd8,    0, 16'd5);
    vecs[21] = mk(1, 1, 1, 10'd100, 1, 0, 32'h0,         10'd0,    10'd0,    0, 16'd0);

    rst = 1'b1;
    bus.DecodeReady  = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 10'd0;

    for (int i = 0; i < 22; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Halt sequence: halt word at address 8
    mem[2] = 32'hFFFF_FFFF;
    step(mk(1, 0, 0, 10'd0, 1, 0, 32'h0,  10'd0, 10'd0, 0, 16'd0), "halt_rst");
    step(mk(0, 1, 0, 10'd0, 1, 1, 32'h11, 10'd0, 10'd4, 0, 16'd0), "halt_w0");
    step(mk(0, 1, 0, 10'd0, 1, 1, 32'h22, 10'd4, 10'd8, 0, 16'd1), "halt_w1");
    step(mk(0, 1, 0, 10'd0, 0, 0, 32'h0,  10'd0, 10'd8, 1, 16'd2), "halt_enter");
    for (int i = 0; i < 10; i++)
      step(mk(0, 1, 0, 10'd0, 0, 0, 32'h0, 10'd0, 10'd8, 1, 16'd2), $sformatf("halt_hold%0d", i));
    step(mk(0, 0, 1, 10'd0, 0, 0, 32'h0,  10'd0, 10'd0, 0, 16'd2), "halt_redirect");
    step(mk(0, 1, 0, 10'd0, 1, 1, 32'h11, 10'd0, 10'd4, 0, 16'd2), "halt_resume0");
    step(mk(0, 1, 0, 10'd0, 1, 1, 32'h22, 10'd4, 10'd8, 0, 16'd3), "halt_resume1");
    step(mk(0, 1, 0, 10'd0, 0, 0, 32'h0,  10'd0, 10'd8, 1, 16'd4), "halt_again");
    step(mk(1, 1, 0, 10'd0, 1, 0, 32'h0,  10'd0, 10'd0, 0, 16'd0), "halt_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
